gameover_fade_ctrl: RTL

GAMEOVER_FADE_CTRL -- requirements
Module: gameover_fade_ctrl

---
 rtl/gameover_fade_ctrl_pkg.sv | 23 ++
 rtl/gameover_fade_ctrl_if.sv | 28 ++
 rtl/gameover_fade_ctrl_fade_scaler.sv | 23 ++
 rtl/gameover_fade_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/gameover_fade_ctrl_pkg.sv
// Shared types and constants for the game-over fade controller.
// Palette entries are {red, green, blue}, 4 bits each.
package gameover_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FADE_IN,
        HOLD,
        FADE_OUT
    } fade_state_e;

    localparam int unsigned DEF_STEP_FRAMES = 4;
    localparam int unsigned DEF_HOLD_FRAMES = 120;

    // Index 15 is the leftmost entry, index 0 the rightmost.
    localparam logic [15:0][11:0] PALETTE = {
        12'h000, 12'h300, 12'hD00, 12'h000,
        12'h700, 12'hC00, 12'h900, 12'hB00,
        12'h200, 12'h500, 12'h100, 12'hA00,
        12'h400, 12'h600, 12'hC00, 12'h000
    };

endpackage

// File: rtl/gameover_fade_ctrl_if.sv
// Control, status and pixel signals of the fade controller.
// The master side drives requests and pixels, the slave side answers.
interface gameover_fade_ctrl_if;

    logic       start;
    logic       abort;
    logic       vsync_tick;
    logic       pix_valid_in;
    logic [3:0] pix_index;
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       pix_valid_out;
    logic [3:0] level;
    logic       busy;
    logic       done;

    modport master (
        output start, abort, vsync_tick, pix_valid_in, pix_index,
        input  red, green, blue, pix_valid_out, level, busy, done
    );

    modport slave (
        input  start, abort, vsync_tick, pix_valid_in, pix_index,
        output red, green, blue, pix_valid_out, level, busy, done
    );

endinterface

// File: rtl/gameover_fade_ctrl_fade_scaler.sv
// One colour channel of the brightness scaler: out = (c*(l+1))>>4,
// forced to black at level 0, registered.
module fade_scaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] c,
    input  logic [3:0] l,
    output logic [3:0] o
);

    logic [7:0] prod;

    assign prod = {4'd0, c} * ({4'd0, l} + 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o <= 4'd0;
        end else begin
            o <= (l == 4'd0) ? 4'd0 : prod[7:4];
        end
    end

endmodule

// File: rtl/gameover_fade_ctrl.sv
// Game-over screen fade: fade-in / hold / fade-out sequencer driven by
// vsync, plus a two-stage palette lookup and brightness scaling path.
module gameover_fade_ctrl
    import gameover_pkg::*;
#(
    parameter int unsigned STEP_FRAMES = DEF_STEP_FRAMES,
    parameter int unsigned HOLD_FRAMES = DEF_HOLD_FRAMES
) (
    input logic                  clk,
    input logic                  rst_n,
    gameover_fade_ctrl_if.slave  bus
);

    localparam logic [9:0] STEP_C = 10'(STEP_FRAMES);
    localparam logic [9:0] HOLD_C = 10'(HOLD_FRAMES);

    fade_state_e state_q, state_d;
    logic [3:0]  level_q, level_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [9:0]  cnt_inc;
    logic        done_q, done_d;

    assign cnt_inc = cnt_q + 10'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            level_q <= 4'd0;
            cnt_q   <= 10'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        // Abort beats every other request, including a tick or a start.
        if (bus.abort) begin
            state_d = IDLE;
            level_d = 4'd0;
            cnt_d   = 10'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    level_d = 4'd0;
                    if (bus.start) begin
                        state_d = FADE_IN;
                        cnt_d   = 10'd0;
                    end
                end
                FADE_IN: if (bus.vsync_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= STEP_C) begin
                        cnt_d = 10'd0;
                        if (level_q != 4'hF) level_d = level_q + 4'd1;
                        if (level_q >= 4'hE) state_d = HOLD;
                    end
                end
                HOLD: if (bus.vsync_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= HOLD_C) begin
                        state_d = FADE_OUT;
                        cnt_d   = 10'd0;
                    end
                end
                FADE_OUT: if (bus.vsync_tick) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= STEP_C) begin
                        cnt_d = 10'd0;
                        if (level_q != 4'h0) level_d = level_q - 4'd1;
                        if (level_q <= 4'h1) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    logic [11:0] pal_q;
    logic        v1_q, v2_q;
    logic [3:0]  r_q, g_q, b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal_q <= 12'd0;
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
        end else begin
            pal_q <= PALETTE[bus.pix_index];
            v1_q  <= bus.pix_valid_in;
            v2_q  <= v1_q;
        end
    end

    fade_scaler u_red (
        .clk   (clk),
        .rst_n (rst_n),
        .c     (pal_q[11:8]),
        .l     (level_q),
        .o     (r_q)
    );

    fade_scaler u_green (
        .clk   (clk),
        .rst_n (rst_n),
        .c     (pal_q[7:4]),
        .l     (level_q),
        .o     (g_q)
    );

    fade_scaler u_blue (
        .clk   (clk),
        .rst_n (rst_n),
        .c     (pal_q[3:0]),
        .l     (level_q),
        .o     (b_q)
    );

    assign bus.red           = r_q;
    assign bus.green         = g_q;
    assign bus.blue          = b_q;
    assign bus.pix_valid_out = v2_q;
    assign bus.level         = level_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_q;

endmodule
